// File: rtl/alu_exec.sv
// alu_exec: miniMips execute stage.
// Single-cycle ADD/SUB/AND/OR/XOR/SHL; MUL (and DIV when ALU_DIV_EN is defined)
// iterate for 8 cycles on a shared 16-bit accumulator. Outputs drive the
// register-file write port directly.
// Build option: ALU_DIV_EN enables the iterative restoring divider for op 111;
// without it op 111 returns 0x00 with carry set in a single cycle.
module alu_exec (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [1:0] dest,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic [1:0] wr_reg,
    output logic       wr_en,
    output logic       zero,
    output logic       carry
);

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpXor = 3'b100;
    localparam logic [2:0] OpShl = 3'b101;
    localparam logic [2:0] OpMul = 3'b110;
    localparam logic [2:0] OpDiv = 3'b111;

    typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

    state_e      state_q;
    logic [2:0]  cnt_q;
    logic [15:0] acc_q;    // MUL: {partial product, multiplier}; DIV: {remainder, dividend}
    logic [7:0]  opnd_q;   // MUL: multiplicand; DIV: divisor
    logic [1:0]  dest_q;
    logic        busy_q;
    logic        done_q;
    logic [7:0]  result_q;
    logic [1:0]  wr_reg_q;
    logic        zero_q;
    logic        carry_q;
`ifdef ALU_DIV_EN
    logic        is_div_q;
`endif

    // Single-cycle result for the operands presented at acceptance
    logic [8:0] add9;
    logic [8:0] sub9;
    logic [8:0] shl9;
    logic [7:0] sc_res;
    logic       sc_carry;
    logic       sc_iter;

    always_comb begin
        add9     = {1'b0, a} + {1'b0, b};
        sub9     = {1'b0, a} - {1'b0, b};
        // Bit 8 holds the last bit shifted out (0 for a zero shift)
        shl9     = {1'b0, a} << b[2:0];
        sc_res   = 8'h00;
        sc_carry = 1'b0;
        sc_iter  = 1'b0;
        unique case (op)
            OpAdd: begin sc_res = add9[7:0]; sc_carry = add9[8]; end
            OpSub: begin sc_res = sub9[7:0]; sc_carry = sub9[8]; end
            OpAnd: sc_res = a & b;
            OpOr:  sc_res = a | b;
            OpXor: sc_res = a ^ b;
            OpShl: begin sc_res = shl9[7:0]; sc_carry = shl9[8]; end
            OpMul: sc_iter = 1'b1;
            OpDiv: begin
`ifdef ALU_DIV_EN
                if (b == 8'h00) begin
                    sc_res   = 8'hFF;
                    sc_carry = 1'b1;
                end else begin
                    sc_iter = 1'b1;
                end
`else
                sc_res   = 8'h00;
                sc_carry = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    // One iteration step of the shift-add multiplier or restoring divider
    logic [8:0]  mul_sum;
    logic [15:0] acc_step;
`ifdef ALU_DIV_EN
    logic [8:0]  div_sh;
    logic [8:0]  div_diff;
`endif

    always_comb begin
        mul_sum  = {1'b0, acc_q[15:8]} + (acc_q[0] ? {1'b0, opnd_q} : 9'd0);
        acc_step = {mul_sum, acc_q[7:1]};
`ifdef ALU_DIV_EN
        div_sh   = {acc_q[15:8], acc_q[7]};
        div_diff = div_sh - {1'b0, opnd_q};
        if (is_div_q) begin
            if (div_sh >= {1'b0, opnd_q}) begin
                acc_step = {div_diff[7:0], acc_q[6:0], 1'b1};
            end else begin
                acc_step = {div_sh[7:0], acc_q[6:0], 1'b0};
            end
        end
`endif
    end

    // Control FSM with registered outputs and the iteration datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= 3'd0;
            acc_q    <= 16'h0000;
            opnd_q   <= 8'h00;
            dest_q   <= 2'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 8'h00;
            wr_reg_q <= 2'd0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
`ifdef ALU_DIV_EN
            is_div_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIter: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_q  <= StDone;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= acc_step[7:0];
                        wr_reg_q <= dest_q;
                        zero_q   <= (acc_step[7:0] == 8'h00);
`ifdef ALU_DIV_EN
                        carry_q  <= is_div_q ? 1'b0 : (acc_step[15:8] != 8'h00);
`else
                        carry_q  <= (acc_step[15:8] != 8'h00);
`endif
                    end
                end
                default: begin
                    // StIdle and StDone both accept a new start
                    if (start) begin
                        dest_q <= dest;
                        if (sc_iter) begin
                            state_q <= StIter;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                            cnt_q   <= 3'd0;
`ifdef ALU_DIV_EN
                            is_div_q <= (op == OpDiv);
                            if (op == OpDiv) begin
                                acc_q  <= {8'h00, a};
                                opnd_q <= b;
                            end else begin
                                acc_q  <= {8'h00, b};
                                opnd_q <= a;
                            end
`else
                            acc_q  <= {8'h00, b};
                            opnd_q <= a;
`endif
                        end else begin
                            state_q  <= StDone;
                            done_q   <= 1'b1;
                            result_q <= sc_res;
                            wr_reg_q <= dest;
                            zero_q   <= (sc_res == 8'h00);
                            carry_q  <= sc_carry;
                        end
                    end else begin
                        state_q <= StIdle;
                        done_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign wr_en  = done_q;
    assign result = result_q;
    assign wr_reg = wr_reg_q;
    assign zero   = zero_q;
    assign carry  = carry_q;

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec against a plain-arithmetic reference model.
module tb_alu_exec;

    logic       clk;
    logic       reset;
    logic       start;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] dest;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic [1:0] wr_reg;
    logic       wr_en;
    logic       zero;
    logic       carry;

    int errors = 0;
    int checks = 0;

    alu_exec dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .dest   (dest),
        .busy   (busy),
        .done   (done),
        .result (result),
        .wr_reg (wr_reg),
        .wr_en  (wr_en),
        .zero   (zero),
        .carry  (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: expected result, carry and latency from plain arithmetic
    function automatic void model(input int o, input int x, input int y,
                                  output logic [7:0] r, output logic c, output int lat);
        int n;
        int v;
        lat = 1;
        c   = 1'b0;
        v   = 0;
        case (o)
            0: begin v = x + y; c = (v > 255); end
            1: begin v = x - y; c = (x < y); end
            2: v = x & y;
            3: v = x | y;
            4: v = x ^ y;
            5: begin
                n = y % 8;
                v = x << n;
                c = (n == 0) ? 1'b0 : 1'((x >> (8 - n)) & 1);
            end
            6: begin v = x * y; c = (v > 255); lat = 9; end
            default: begin
`ifdef ALU_DIV_EN
                if (y == 0) begin v = 255; c = 1'b1; end
                else begin v = x / y; lat = 9; end
`else
                v = 0;
                c = 1'b1;
`endif
            end
        endcase
        r = 8'(v & 255);
    endfunction

    // Issue one op, scramble inputs after acceptance, wait (bounded) for done.
    // If poke > 0, a stray ADD start is pulsed in that cycle of the wait.
    task automatic run_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                          input logic [1:0] d, input int poke,
                          output int lat, output int busy_cycles);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y; dest = d;
        @(posedge clk); #1;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); dest = 2'($urandom); op = 3'($urandom);
        lat = 1;
        busy_cycles = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cycles++;
            if (lat == poke) begin start = 1'b1; op = 3'b000; end
            else start = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        if (!done) lat = 99;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; op = 3'b000; a = 8'h01; b = 8'h01; dest = 2'd3;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({busy, done, wr_en} !== 3'b000) begin errors++;
            $display("FAIL reset_ctrl got=%b exp=000", {busy, done, wr_en}); end
        checks++; if ({result, wr_reg, zero, carry} !== 12'h000) begin errors++;
            $display("FAIL reset_data got=%h exp=000", {result, wr_reg, zero, carry}); end
        start = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++;
            $display("FAIL reset_start_dropped done=%b exp=0", done); end
    endtask

    task automatic test_add();
        int lat, bc;
        run_op(3'b000, 8'hF0, 8'h20, 2'd2, 0, lat, bc);
        checks++; if (lat !== 1) begin errors++; $display("FAIL add_lat got=%0d exp=1", lat); end
        checks++; if ({wr_en, result, carry, zero, wr_reg} !== {1'b1, 8'h10, 1'b1, 1'b0, 2'd2})
            begin errors++; $display("FAIL add_out got=%b_%h_%b_%b_%0d exp=1_10_1_0_2",
                                     wr_en, result, carry, zero, wr_reg); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        start = 1'b1; op = 3'b001; a = 8'h05; b = 8'h05; dest = 2'd1;
        @(posedge clk); #1;
        checks++; if ({done, result, zero, carry} !== {1'b1, 8'h00, 1'b1, 1'b0}) begin errors++;
            $display("FAIL b2b_sub got=%b_%h_%b_%b exp=1_00_1_0", done, result, zero, carry); end
        op = 3'b101; a = 8'h81; b = 8'h01; dest = 2'd3;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if ({done, result, carry, wr_reg} !== {1'b1, 8'h02, 1'b1, 2'd3}) begin errors++;
            $display("FAIL b2b_shl got=%b_%h_%b_%0d exp=1_02_1_3", done, result, carry, wr_reg); end
        @(posedge clk); #1;
        checks++; if ({done, wr_en} !== 2'b00) begin errors++;
            $display("FAIL b2b_idle got=%b exp=00", {done, wr_en}); end
        checks++; if (result !== 8'h02) begin errors++;
            $display("FAIL b2b_hold got=%h exp=02", result); end
    endtask

    task automatic test_mul();
        int lat, bc;
        run_op(3'b110, 8'h12, 8'h34, 2'd1, 4, lat, bc);
        checks++; if (lat !== 9) begin errors++; $display("FAIL mul_lat got=%0d exp=9", lat); end
        checks++; if (bc !== 8) begin errors++; $display("FAIL mul_busy got=%0d exp=8", bc); end
        checks++; if ({result, carry, zero, wr_reg} !== {8'hA8, 1'b1, 1'b0, 2'd1}) begin
            errors++; $display("FAIL mul_out got=%h_%b_%b_%0d exp=a8_1_0_1",
                               result, carry, zero, wr_reg); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++;
            $display("FAIL mul_ignored_start done=%b exp=0", done); end
    endtask

    task automatic test_div();
        int lat, bc;
        logic [7:0] er;
        logic ec;
        int el;
        model(7, 200, 7, er, ec, el);
        run_op(3'b111, 8'd200, 8'd7, 2'd0, 0, lat, bc);
        checks++; if (lat !== el) begin errors++; $display("FAIL div_lat got=%0d exp=%0d", lat, el); end
        checks++; if ({result, carry} !== {er, ec}) begin errors++;
            $display("FAIL div_out got=%h_%b exp=%h_%b", result, carry, er, ec); end
        model(7, 9, 0, er, ec, el);
        run_op(3'b111, 8'd9, 8'd0, 2'd2, 0, lat, bc);
        checks++; if (lat !== 1) begin errors++; $display("FAIL div0_lat got=%0d exp=1", lat); end
        checks++; if ({result, carry, zero} !== {er, ec, er == 8'h00}) begin errors++;
            $display("FAIL div0_out got=%h_%b_%b exp=%h_%b", result, carry, zero, er, ec); end
    endtask

    task automatic test_reset_in_iter();
        int lat, bc;
        int pulses = 0;
        @(negedge clk);
        start = 1'b1; op = 3'b110; a = 8'h0F; b = 8'h0F; dest = 2'd3;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (wr_en) pulses++;
            @(posedge clk); #1;
        end
        checks++; if (busy !== 1'b1) begin errors++;
            $display("FAIL rst_iter_busy got=%b exp=1", busy); end
        reset = 1'b1;
        @(posedge clk); #1;
        if (wr_en) pulses++;
        checks++; if ({busy, done, wr_en, result, wr_reg, zero, carry} !== 15'h0) begin errors++;
            $display("FAIL rst_iter_state got=%h exp=0",
                     {busy, done, wr_en, result, wr_reg, zero, carry}); end
        reset = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (wr_en) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++;
            $display("FAIL rst_iter_wren got=%0d exp=0", pulses); end
        run_op(3'b000, 8'h11, 8'h22, 2'd1, 0, lat, bc);
        checks++; if ({lat == 1, result, wr_reg} !== {1'b1, 8'h33, 2'd1}) begin errors++;
            $display("FAIL rst_iter_add got=%0d_%h_%0d exp=1_33_1", lat, result, wr_reg); end
    endtask

    task automatic test_random();
        int lat, bc, el;
        logic [7:0] er, x, y;
        logic ec;
        logic [2:0] o;
        logic [1:0] d;
        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom);
            x = 8'($urandom);
            y = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            d = 2'($urandom);
            model(int'(o), int'(x), int'(y), er, ec, el);
            run_op(o, x, y, d, (el > 1) ? int'($urandom_range(1, 8)) : 0, lat, bc);
            checks++; if (lat !== el) begin errors++;
                $display("FAIL rnd_lat op=%0d a=%h b=%h got=%0d exp=%0d", o, x, y, lat, el); end
            checks++; if ({result, carry, zero, wr_reg, wr_en} !== {er, ec, er == 8'h00, d, 1'b1})
                begin errors++;
                $display("FAIL rnd_out op=%0d a=%h b=%h got=%h_%b_%b_%0d_%b exp=%h_%b_%b_%0d_1",
                         o, x, y, result, carry, zero, wr_reg, wr_en, er, ec, er == 8'h00, d);
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'b000; a = 8'h00; b = 8'h00; dest = 2'd0;
        test_reset();
        test_add();
        test_back_to_back();
        test_mul();
        test_div();
        test_reset_in_iter();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
